// File: rtl/hyperram_avmm_arb.sv
// hyperram_avmm_arb: two-port Avalon-MM burst arbiter in front of the single
// HyperRAM controller slave. Whole bursts are granted round-robin and only one
// transaction is ever outstanding, so returning read data is simply routed to
// the current owner without any tagging.
module hyperram_avmm_arb #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic [BURST_W-1:0]  s0_burstcount,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [BURST_W-1:0]  s1_burstcount,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [BURST_W-1:0]  m_burstcount,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_DATA} state_e;

  localparam logic [BURST_W-1:0] BC_ONE = BURST_W'(1);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;     // index of the port granted last
  logic [BURST_W-1:0]   beats_q, beats_d;   // 0 in WR means no beat accepted yet
  logic                 stray_rdv_q;

  logic                 req0, req1, win, owner;
  logic                 own_read, own_write;
  logic [BURST_W-1:0]   own_bc, own_bc_eff;

  assign req0  = s0_read | s0_write;
  assign req1  = s1_read | s1_write;
  // On a tie the port that did not win last time goes next.
  assign win   = (req0 & req1) ? ~last_q : req1;
  assign owner = grant_q[1];

  assign own_read   = owner ? s1_read : s0_read;
  assign own_write  = owner ? s1_write : s0_write;
  assign own_bc     = owner ? s1_burstcount : s0_burstcount;
  assign own_bc_eff = (own_bc == '0) ? BC_ONE : own_bc;

  assign m_address    = owner ? s1_address : s0_address;
  assign m_writedata  = owner ? s1_writedata : s0_writedata;
  assign m_byteenable = owner ? s1_byteenable : s0_byteenable;
  assign m_burstcount = own_bc;

  // Both requesters see the controller read bus; only the valid is steered.
  assign s0_readdata = m_readdata;
  assign s1_readdata = m_readdata;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  // State, grant, round-robin pointer and beat counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  // Next-state logic plus the state-gated command strobes and handshakes.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    beats_d          = beats_q;
    m_read           = 1'b0;
    m_write          = 1'b0;
    s0_waitrequest   = 1'b1;
    s1_waitrequest   = 1'b1;
    s0_readdatavalid = 1'b0;
    s1_readdatavalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = win ? 2'b10 : 2'b01;
          // A port raising read and write together is treated as a write.
          state_d = (win ? s1_write : s0_write) ? WR : RD_CMD;
        end
      end
      WR: begin
        m_write = own_write;
        if (owner) s1_waitrequest = m_waitrequest;
        else       s0_waitrequest = m_waitrequest;
        if (own_write && !m_waitrequest) begin
          if (beats_q == '0) beats_d = own_bc_eff - BC_ONE;
          else               beats_d = beats_q - BC_ONE;
          if (beats_q == BC_ONE || (beats_q == '0 && own_bc_eff == BC_ONE)) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = owner;
          end
        end
      end
      RD_CMD: begin
        m_read = own_read;
        if (owner) s1_waitrequest = m_waitrequest;
        else       s0_waitrequest = m_waitrequest;
        if (own_read && !m_waitrequest) begin
          beats_d = own_bc_eff;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (owner) s1_readdatavalid = m_readdatavalid;
        else       s0_readdatavalid = m_readdatavalid;
        if (m_readdatavalid) begin
          beats_d = beats_q - BC_ONE;
          if (beats_q == BC_ONE) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = owner;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky record of read data arriving while no read is in its data phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     stray_rdv_q <= 1'b0;
    else if (m_readdatavalid && state_q != RD_DATA) stray_rdv_q <= 1'b1;
  end

  stray_rdv: assert property (@(posedge clk) disable iff (!reset_n) !stray_rdv_q);
  s0_rw_conflict: assert property (@(posedge clk) disable iff (!reset_n) !(s0_read && s0_write));
  s1_rw_conflict: assert property (@(posedge clk) disable iff (!reset_n) !(s1_read && s1_write));

endmodule

// File: tb/tb_hyperram_avmm_arb.sv
// Bench for hyperram_avmm_arb: a cycle table for short write handshakes, then
// scripted and random bursts checked against a transaction-level arbiter model.
module tb_hyperram_avmm_arb;

  logic        clk, reset_n;
  logic [21:0] s0_address, s1_address, m_address;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [15:0] s0_writedata, s1_writedata, s0_readdata, s1_readdata;
  logic [1:0]  s0_byteenable, s1_byteenable, m_byteenable;
  logic [7:0]  s0_burstcount, s1_burstcount, m_burstcount;
  logic        s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [15:0] m_writedata, m_readdata;
  logic [1:0]  grant;
  logic        busy;

  logic [1:0]  swait, srdv, sw_in;
  logic [15:0] srdata [2];
  assign swait = {s1_waitrequest, s0_waitrequest};
  assign srdv  = {s1_readdatavalid, s0_readdatavalid};
  assign sw_in = {s1_write, s0_write};
  assign srdata[0] = s0_readdata;
  assign srdata[1] = s1_readdata;

  hyperram_avmm_arb #(.ADDR_W(22), .DATA_W(16), .BURST_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable), .s0_burstcount(s0_burstcount),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable), .s1_burstcount(s1_burstcount),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks, failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    bit          wr;
    logic [21:0] addr;
    logic [7:0]  bc;
    logic [15:0] dbase;
    logic [1:0]  be;
    int          dly;
  } burst_t;

  burst_t bq0[$], bq1[$];
  burst_t cur;
  int     own, last, rem, phase;  // phase 0 write, 1 read command, 2 read data
  int     bi [2], age [2];
  bit     pres [2];
  bit     just;
  int     rdq;                    // read beats the controller still owes
  int     wmode, rmode;           // waitrequest: 0 low,1 random,2 scripted; rdv: 0 always,1 random
  bit     wq[$];
  int     glog[$];
  int     acc_cnt [2], rdv_cnt [2], stall_cnt [2];

  function automatic int bce(input logic [7:0] b);
    return (b == 8'd0) ? 1 : int'(b);
  endfunction

  function automatic burst_t mk(input bit wr, input logic [21:0] a, input logic [7:0] bc,
                                input logic [15:0] d, input int dly);
    burst_t b;
    b.wr = wr; b.addr = a; b.bc = bc; b.dbase = d; b.be = 2'b11; b.dly = dly;
    return b;
  endfunction

  function automatic burst_t head(input int n);
    return (n == 0) ? bq0[0] : bq1[0];
  endfunction

  function automatic int qsize(input int n);
    return (n == 0) ? bq0.size() : bq1.size();
  endfunction

  task automatic pop_port(input int n);
    if (n == 0) void'(bq0.pop_front());
    else        void'(bq1.pop_front());
    age[n] = 0;
    bi[n]  = 0;
  endtask

  task automatic model_reset();
    own = -1; last = 1; rem = 0; phase = 0; just = 0; rdq = 0;
    bi = '{0, 0}; age = '{0, 0}; pres = '{0, 0};
    acc_cnt = '{0, 0}; rdv_cnt = '{0, 0}; stall_cnt = '{0, 0};
    bq0.delete(); bq1.delete(); glog.delete(); wq.delete();
    wmode = 0; rmode = 0;
  endtask

  task automatic idle_inputs();
    s0_address = '0; s0_read = 0; s0_write = 0; s0_writedata = '0; s0_byteenable = '0; s0_burstcount = '0;
    s1_address = '0; s1_read = 0; s1_write = 0; s1_writedata = '0; s1_byteenable = '0; s1_burstcount = '0;
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wait", swait, 2'b11);
    chk("rst_rdv", srdv, 0);
    chk("rst_cmd", {m_read, m_write}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    model_reset();
  endtask

  task automatic drive_port(input int n, input bit p);
    burst_t h;
    logic rd, wr; logic [21:0] a; logic [15:0] d; logic [1:0] be; logic [7:0] bc;
    rd = 0; wr = 0; a = '0; d = '0; be = '0; bc = '0;
    if (p) begin
      h = head(n);
      wr = h.wr; rd = !h.wr; a = h.addr; d = h.dbase + 16'(bi[n]); be = h.be; bc = h.bc;
    end
    if (n == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_writedata = d; s0_byteenable = be; s0_burstcount = bc;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_writedata = d; s1_byteenable = be; s1_burstcount = bc;
    end
  endtask

  // One clock: entered and left at posedge+1.
  task automatic cycle();
    int oth;
    for (int n = 0; n < 2; n++) begin
      pres[n] = 0;
      if (qsize(n) > 0) pres[n] = (age[n] >= head(n).dly);
      drive_port(n, pres[n]);
    end
    if (wmode == 1)                       m_waitrequest = ($urandom_range(3) == 0);
    else if (wmode == 2 && wq.size() > 0) m_waitrequest = wq.pop_front();
    else                                  m_waitrequest = 0;
    m_readdatavalid = (rdq > 0) && (rmode == 0 || $urandom_range(1) == 1);
    m_readdata = 16'($urandom);
    #2;
    // compare the DUT against the model's view of this cycle
    if (just) glog.push_back(int'(grant));
    if (own < 0) begin
      chk("idle_grant", grant, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmd", {m_read, m_write}, 0);
      chk("idle_wait", swait, 2'b11);
      chk("idle_rdv", srdv, 0);
    end else begin
      oth = 1 - own;
      chk("own_grant", grant, 1 << own);
      chk("own_busy", busy, 1);
      if (phase == 2) begin
        chk("rdd_cmd", {m_read, m_write}, 0);
        chk("rdd_wait", swait, 2'b11);
        chk("rdd_rdv_own", srdv[own], m_readdatavalid);
        chk("rdd_rdv_oth", srdv[oth], 0);
        chk("rdd_data0", srdata[0], m_readdata);
        chk("rdd_data1", srdata[1], m_readdata);
      end else begin
        chk("cmd_strobes", {m_read, m_write}, (phase == 0) ? 2'b01 : 2'b10);
        chk("cmd_addr", m_address, cur.addr);
        chk("cmd_bc", m_burstcount, cur.bc);
        chk("cmd_wait_own", swait[own], m_waitrequest);
        chk("cmd_wait_oth", swait[oth], 1);
        if (phase == 0) begin
          chk("wr_data", m_writedata, cur.dbase + 16'(bi[own]));
          chk("wr_be", m_byteenable, cur.be);
        end
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (sw_in[n] && !swait[n]) acc_cnt[n]++;
      if (sw_in[n] && swait[n] && grant[n]) stall_cnt[n]++;
      if (srdv[n]) rdv_cnt[n]++;
    end
    // advance the model to the state after the coming edge
    just = 0;
    age[0]++; age[1]++;
    if (own < 0) begin
      if (pres[0] || pres[1]) begin
        own   = (pres[0] && pres[1]) ? 1 - last : (pres[0] ? 0 : 1);
        cur   = head(own);
        phase = cur.wr ? 0 : 1;
        rem   = bce(cur.bc);
        just  = 1;
      end
    end else if (phase == 0) begin
      if (!m_waitrequest) begin
        bi[own]++;
        rem--;
        if (rem == 0) begin pop_port(own); last = own; own = -1; end
      end
    end else if (phase == 1) begin
      if (!m_waitrequest) begin rdq += rem; pop_port(own); phase = 2; end
    end else begin
      if (m_readdatavalid) begin
        rdq--;
        rem--;
        if (rem == 0) begin last = own; own = -1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int maxc, input string nm);
    int c;
    c = 0;
    while (!(own < 0 && bq0.size() == 0 && bq1.size() == 0) && c < maxc) begin
      cycle();
      c++;
    end
    chk(nm, (c < maxc), 1);
  endtask

  task automatic chk_glog(input string nm, input int exp[$]);
    chk({nm, "_len"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(nm, (i < glog.size()) ? glog[i] : -1, exp[i]);
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct packed {
    logic       s0w;
    logic       s1w;
    logic [7:0] bc;
    logic       mw;
    logic [1:0] eg;
    logic       eb;
    logic       emw;
    logic       es0w;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int exp_wr [2], exp_rd [2];
    burst_t b;
    checks = 0;
    failures = 0;
    model_reset();
    do_reset();

    // s0 writes 0xA5A5 @0x10, s1 writes 0x5A5A @0x20
    tbl[0] = '{1'b0, 1'b0, 8'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'd1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'd0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 8'd0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    s0_address = 22'h10; s0_writedata = 16'hA5A5; s0_byteenable = 2'b11;
    s1_address = 22'h20; s1_writedata = 16'h5A5A; s1_byteenable = 2'b11;
    for (int i = 0; i < 10; i++) begin
      s0_write = tbl[i].s0w; s1_write = tbl[i].s1w;
      s0_burstcount = tbl[i].bc; s1_burstcount = tbl[i].bc;
      m_waitrequest = tbl[i].mw;
      #2;
      chk("tbl_grant", grant, tbl[i].eg);
      chk("tbl_busy", busy, tbl[i].eb);
      chk("tbl_mwrite", m_write, tbl[i].emw);
      chk("tbl_s0wait", s0_waitrequest, tbl[i].es0w);
      if (tbl[i].emw) begin
        chk("tbl_addr", m_address, (tbl[i].eg == 2'b10) ? 22'h20 : 22'h10);
        chk("tbl_data", m_writedata, (tbl[i].eg == 2'b10) ? 16'h5A5A : 16'hA5A5);
      end
      @(posedge clk);
      #1;
    end

    // both ports issue a 4-beat read in the same cycle
    do_reset();
    bq0.push_back(mk(0, 22'h100, 8'd4, 16'h0, 0));
    bq1.push_back(mk(0, 22'h200, 8'd4, 16'h0, 0));
    run(200, "t2_done");
    chk_glog("t2_grant", '{1, 2});
    chk("t2_rdv0", rdv_cnt[0], 4);
    chk("t2_rdv1", rdv_cnt[1], 4);

    // port1 8-beat write stalled on beats 3 and 6, port0 arrives later
    do_reset();
    wmode = 2;
    wq = '{0, 0, 0, 1, 0, 0, 0, 1};
    bq1.push_back(mk(1, 22'h300, 8'd8, 16'h1000, 0));
    bq0.push_back(mk(1, 22'h040, 8'd1, 16'h2000, 2));
    run(200, "t3_done");
    chk_glog("t3_grant", '{2, 1});
    chk("t3_acc1", acc_cnt[1], 8);
    chk("t3_acc0", acc_cnt[0], 1);
    chk("t3_stall1", stall_cnt[1], 2);

    // continuous 2-beat reads from both ports alternate
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bq0.push_back(mk(0, 22'(22'h400 + i), 8'd2, 16'h0, 0));
      bq1.push_back(mk(0, 22'(22'h800 + i), 8'd2, 16'h0, 0));
    end
    run(300, "t4_done");
    chk_glog("t4_grant", '{1, 2, 1, 2, 1, 2});

    // asynchronous reset after two of four read beats
    do_reset();
    bq0.push_back(mk(0, 22'h500, 8'd4, 16'h0, 0));
    for (int c = 0; c < 20 && rdv_cnt[0] < 2; c++) cycle();
    chk("t5_two_beats", rdv_cnt[0], 2);
    m_readdatavalid = 1;
    m_waitrequest = 0;
    #1;
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_rdv", s0_readdatavalid, 1);
    reset_n = 0;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rdv", srdv, 0);
    chk("t5_wait", swait, 2'b11);
    do_reset();
    bq0.push_back(mk(1, 22'h600, 8'd1, 16'h3000, 0));
    bq1.push_back(mk(1, 22'h700, 8'd1, 16'h4000, 0));
    run(100, "t5_tie_done");
    chk_glog("t5_tie", '{1, 2});

    // random bursts with random stalls and read data gaps
    do_reset();
    wmode = 1;
    rmode = 1;
    exp_wr = '{0, 0};
    exp_rd = '{0, 0};
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 24; i++) begin
        b = mk($urandom_range(1), 22'($urandom), 8'($urandom_range(8)), 16'($urandom),
               $urandom_range(3));
        b.be = 2'($urandom);
        if (b.wr) exp_wr[n] += bce(b.bc);
        else      exp_rd[n] += bce(b.bc);
        if (n == 0) bq0.push_back(b);
        else        bq1.push_back(b);
      end
    end
    run(8000, "rnd_done");
    for (int n = 0; n < 2; n++) begin
      chk("rnd_wr_beats", acc_cnt[n], exp_wr[n]);
      chk("rnd_rd_beats", rdv_cnt[n], exp_rd[n]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
